// File: rtl/mini_risc_pkg.sv
// mini_risc_pkg: shared definitions for the miniRISC core.
//   - opcode constants (5-bit, decimal values of the ISA)
//   - FSM state encoding (fixed values, observable from outside)
//   - instruction-word field positions
//   - enc_instr(): builds a 32-bit instruction word for the ROM tables
package mini_risc_pkg;

  localparam logic [4:0] OP_MOVSGPR  = 5'd0;
  localparam logic [4:0] OP_MOV      = 5'd1;
  localparam logic [4:0] OP_ADD      = 5'd2;
  localparam logic [4:0] OP_SUB      = 5'd3;
  localparam logic [4:0] OP_MUL      = 5'd4;
  localparam logic [4:0] OP_ROR      = 5'd5;
  localparam logic [4:0] OP_AND      = 5'd6;
  localparam logic [4:0] OP_XOR      = 5'd7;
  localparam logic [4:0] OP_XNOR     = 5'd8;
  localparam logic [4:0] OP_NAND     = 5'd9;
  localparam logic [4:0] OP_NOR      = 5'd10;
  localparam logic [4:0] OP_NOT      = 5'd11;
  localparam logic [4:0] OP_STOREREG = 5'd12;
  localparam logic [4:0] OP_STOREDIN = 5'd13;
  localparam logic [4:0] OP_SENDDOUT = 5'd14;
  localparam logic [4:0] OP_SENDREG  = 5'd15;
  localparam logic [4:0] OP_JUMP     = 5'd16;
  localparam logic [4:0] OP_JCARRY   = 5'd17;
  localparam logic [4:0] OP_JNOCARRY = 5'd18;
  localparam logic [4:0] OP_JSIGN    = 5'd19;
  localparam logic [4:0] OP_JNOSIGN  = 5'd20;
  localparam logic [4:0] OP_JZERO    = 5'd21;
  localparam logic [4:0] OP_JNOZERO  = 5'd22;
  localparam logic [4:0] OP_JOVF     = 5'd23;
  localparam logic [4:0] OP_JNOOVF   = 5'd24;
  localparam logic [4:0] OP_HALT     = 5'd25;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_EXEC    = 3'd2,
    ST_DELAY   = 3'd3,
    ST_NEXT    = 3'd4,
    ST_HALTCHK = 3'd5
  } state_e;

  localparam int IR_OP_MSB    = 31;
  localparam int IR_OP_LSB    = 27;
  localparam int IR_RDST_MSB  = 26;
  localparam int IR_RDST_LSB  = 22;
  localparam int IR_RSRC1_MSB = 21;
  localparam int IR_RSRC1_LSB = 17;
  localparam int IR_IMM_MODE  = 16;
  localparam int IR_RSRC2_MSB = 15;
  localparam int IR_RSRC2_LSB = 11;
  localparam int IR_IMM_MSB   = 15;

  // Register-operand forms carry rsrc2 in imm16[15:11].
  function automatic logic [31:0] enc_instr(input logic [4:0] op, input logic [4:0] rdst,
                                            input logic [4:0] rsrc1, input logic imm_mode,
                                            input logic [15:0] imm16);
    return {op, rdst, rsrc1, imm_mode, imm16};
  endfunction

endpackage

// File: rtl/mini_risc_alu.sv
// mini_risc_alu: combinational datapath for ops 2..11 (and 4 when enabled).
//   op       in  5   opcode
//   a, b     in  16  operands (b already muxed between imm16 and GPR)
//   result32 out 32  result; only MUL uses the upper half
//   zero, sign, carry, overflow out 1  flag values for this result
// MINIRISC_MUL_EN: when defined, op 4 produces the 32-bit product;
// otherwise no multiplier exists and op 4 yields 0.
module mini_risc_alu
  import mini_risc_pkg::*;
(
  input  logic [4:0]  op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] result32,
  output logic        zero,
  output logic        sign,
  output logic        carry,
  output logic        overflow
);

  logic [16:0] sum17_s;
  logic [16:0] diff17_s;
  logic [15:0] rot_s;

  assign sum17_s  = {1'b0, a} + {1'b0, b};
  assign diff17_s = {1'b0, a} - {1'b0, b};
  // Rotating right is a right shift of the doubled word.
  assign rot_s    = 16'({a, a} >> b[3:0]);

  // Result and carry/overflow selection per opcode.
  always_comb begin
    result32 = 32'd0;
    carry    = 1'b0;
    overflow = 1'b0;
    case (op)
      OP_ADD: begin
        result32 = {16'd0, sum17_s[15:0]};
        carry    = sum17_s[16];
        overflow = (a[15] == b[15]) && (sum17_s[15] != a[15]);
      end
      OP_SUB: begin
        result32 = {16'd0, diff17_s[15:0]};
        carry    = diff17_s[16];
        overflow = (a[15] != b[15]) && (diff17_s[15] != a[15]);
      end
`ifdef MINIRISC_MUL_EN
      OP_MUL:  result32 = {16'd0, a} * {16'd0, b};
`endif
      OP_ROR:  result32 = {16'd0, rot_s};
      OP_AND:  result32 = {16'd0, a & b};
      OP_XOR:  result32 = {16'd0, a ^ b};
      OP_XNOR: result32 = {16'd0, ~(a ^ b)};
      OP_NAND: result32 = {16'd0, ~(a & b)};
      OP_NOR:  result32 = {16'd0, ~(a | b)};
      OP_NOT:  result32 = {16'd0, ~b};
      default: result32 = 32'd0;
    endcase
  end

  // The multiply zero test spans the whole product.
  assign zero = (op == OP_MUL) ? (result32 == 32'd0) : (result32[15:0] == 16'd0);
  assign sign = result32[15];

endmodule

// File: rtl/mini_risc_core.sv
// mini_risc_core: multi-cycle 16-bit miniRISC CPU with built-in program ROM.
//   clk      in  1   rising-edge clock
//   sys_rst  in  1   asynchronous active-low reset
//   din      in  16  external word, captured by STOREDIN
//   dout     out 16  output register, loaded by SENDDOUT
// Each instruction walks FETCH, EXEC, DELAY (DELAY_CYCLES), NEXT, HALTCHK.
// ROM_VARIANT 0 is the 5*6 repeated-addition program; 1 is a short
// MUL R5,R0,R1 program. Unlisted ROM words and PCs >= IMEM_DEPTH read HALT.
// MINIRISC_MUL_EN: enables op 4 (MUL) and the SGPR write path.
module mini_risc_core
  import mini_risc_pkg::*;
#(
  parameter int IMEM_DEPTH   = 16,
  parameter int DMEM_DEPTH   = 16,
  parameter int DELAY_CYCLES = 5,
  parameter int ROM_VARIANT  = 0
) (
  input  logic        clk,
  input  logic        sys_rst,
  input  logic [15:0] din,
  output logic [15:0] dout
);

  localparam int         AW       = $clog2(DMEM_DEPTH);
  localparam logic [7:0] DLY_LAST = 8'(DELAY_CYCLES - 1);
  localparam logic [31:0] HALT_W  = enc_instr(OP_HALT, 5'd0, 5'd0, 1'b1, 16'd0);

  state_e      state_r;
  logic [15:0] pc_r;
  logic [31:0] ir_r;
  logic [15:0] gpr_r [32];
  logic [15:0] sgpr_r;
  logic        zero_r, sign_r, carry_r, ovf_r;
  logic        jmp_flag_r, stop_r;
  logic [7:0]  dly_cnt_r;
  logic [15:0] dout_r;
  logic [15:0] dmem_r [DMEM_DEPTH];

  logic [4:0]    op_s, rdst_s, rsrc1_s, rsrc2_s;
  logic          imm_mode_s;
  logic [15:0]   imm_s, b_s;
  logic [AW-1:0] addr_s;
  logic [31:0]   alu_res_s;
  logic          alu_zero_s, alu_sign_s, alu_carry_s, alu_ovf_s;
  logic          flag_upd_s, branch_s;

  assign op_s       = ir_r[IR_OP_MSB:IR_OP_LSB];
  assign rdst_s     = ir_r[IR_RDST_MSB:IR_RDST_LSB];
  assign rsrc1_s    = ir_r[IR_RSRC1_MSB:IR_RSRC1_LSB];
  assign imm_mode_s = ir_r[IR_IMM_MODE];
  assign rsrc2_s    = ir_r[IR_RSRC2_MSB:IR_RSRC2_LSB];
  assign imm_s      = ir_r[IR_IMM_MSB:0];
  assign b_s        = imm_mode_s ? imm_s : gpr_r[rsrc2_s];
  // Data memory depth is a power of two, so the low bits are imm16 mod depth.
  assign addr_s     = imm_s[AW-1:0];
  assign dout       = dout_r;

  function automatic logic [31:0] rom_word(input logic [15:0] addr);
    logic [31:0] w;
    w = HALT_W;
    if (addr >= 16'(IMEM_DEPTH)) begin
      w = HALT_W;
    end else if (ROM_VARIANT == 1) begin
      case (addr)
        16'd0:   w = enc_instr(OP_MOV, 5'd0, 5'd0, 1'b1, 16'd5);
        16'd1:   w = enc_instr(OP_MOV, 5'd1, 5'd0, 1'b1, 16'd6);
        16'd2:   w = enc_instr(OP_MUL, 5'd5, 5'd0, 1'b0, {5'd1, 11'd0});
        default: w = HALT_W;
      endcase
    end else begin
      case (addr)
        16'd0:   w = enc_instr(OP_MOV,     5'd0, 5'd0, 1'b1, 16'd5);
        16'd1:   w = enc_instr(OP_MOV,     5'd1, 5'd0, 1'b1, 16'd6);
        16'd2:   w = enc_instr(OP_MOV,     5'd2, 5'd0, 1'b1, 16'd0);
        16'd3:   w = enc_instr(OP_MOV,     5'd3, 5'd0, 1'b0, {5'd1, 11'd0});
        16'd4:   w = enc_instr(OP_ADD,     5'd2, 5'd2, 1'b0, {5'd0, 11'd0});
        16'd5:   w = enc_instr(OP_SUB,     5'd3, 5'd3, 1'b1, 16'd1);
        16'd6:   w = enc_instr(OP_JNOZERO, 5'd0, 5'd0, 1'b1, 16'd4);
        16'd7:   w = enc_instr(OP_MOV,     5'd4, 5'd0, 1'b0, {5'd2, 11'd0});
        default: w = HALT_W;
      endcase
    end
    return w;
  endfunction

  mini_risc_alu u_alu (
    .op       (op_s),
    .a        (gpr_r[rsrc1_s]),
    .b        (b_s),
    .result32 (alu_res_s),
    .zero     (alu_zero_s),
    .sign     (alu_sign_s),
    .carry    (alu_carry_s),
    .overflow (alu_ovf_s)
  );

`ifndef MINIRISC_MUL_EN
  // Product upper half has no consumer without the multiplier.
  logic unused_hi_s;
  assign unused_hi_s = ^alu_res_s[31:16];
`endif

  // Which opcodes refresh the flags.
  always_comb begin
    flag_upd_s = 1'b0;
    case (op_s)
      OP_ADD, OP_SUB, OP_ROR, OP_AND, OP_XOR,
      OP_XNOR, OP_NAND, OP_NOR, OP_NOT: flag_upd_s = 1'b1;
`ifdef MINIRISC_MUL_EN
      OP_MUL:  flag_upd_s = 1'b1;
`endif
      default: flag_upd_s = 1'b0;
    endcase
  end

  // Branch condition evaluated against the held flags.
  always_comb begin
    branch_s = 1'b0;
    case (op_s)
      OP_JUMP:     branch_s = 1'b1;
      OP_JCARRY:   branch_s = carry_r;
      OP_JNOCARRY: branch_s = ~carry_r;
      OP_JSIGN:    branch_s = sign_r;
      OP_JNOSIGN:  branch_s = ~sign_r;
      OP_JZERO:    branch_s = zero_r;
      OP_JNOZERO:  branch_s = ~zero_r;
      OP_JOVF:     branch_s = ovf_r;
      OP_JNOOVF:   branch_s = ~ovf_r;
      default:     branch_s = 1'b0;
    endcase
  end

  // Data memory writes; contents are not part of reset.
  always_ff @(posedge clk) begin
    if (state_r == ST_EXEC && op_s == OP_STOREREG) begin
      dmem_r[addr_s] <= gpr_r[rsrc1_s];
    end else if (state_r == ST_EXEC && op_s == OP_STOREDIN) begin
      dmem_r[addr_s] <= din;
    end
  end

  // Instruction sequencer, register file, flags and output register.
  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_r    <= ST_IDLE;
      pc_r       <= 16'd0;
      ir_r       <= 32'd0;
      sgpr_r     <= 16'd0;
      zero_r     <= 1'b0;
      sign_r     <= 1'b0;
      carry_r    <= 1'b0;
      ovf_r      <= 1'b0;
      jmp_flag_r <= 1'b0;
      stop_r     <= 1'b0;
      dly_cnt_r  <= 8'd0;
      dout_r     <= 16'd0;
      for (int i = 0; i < 32; i++) gpr_r[i] <= 16'd0;
    end else begin
      case (state_r)
        ST_IDLE:  state_r <= ST_FETCH;
        ST_FETCH: begin
          ir_r    <= rom_word(pc_r);
          state_r <= ST_EXEC;
        end
        ST_EXEC: begin
          dly_cnt_r  <= 8'd0;
          state_r    <= ST_DELAY;
          jmp_flag_r <= branch_s;
          case (op_s)
            OP_MOVSGPR: gpr_r[rdst_s] <= sgpr_r;
            OP_MOV:     gpr_r[rdst_s] <= b_s;
            OP_ADD, OP_SUB, OP_ROR, OP_AND, OP_XOR,
            OP_XNOR, OP_NAND, OP_NOR, OP_NOT: gpr_r[rdst_s] <= alu_res_s[15:0];
`ifdef MINIRISC_MUL_EN
            OP_MUL: begin
              gpr_r[rdst_s] <= alu_res_s[15:0];
              sgpr_r        <= alu_res_s[31:16];
            end
`endif
            OP_SENDDOUT: dout_r        <= dmem_r[addr_s];
            OP_SENDREG:  gpr_r[rdst_s] <= dmem_r[addr_s];
            OP_HALT:     stop_r        <= 1'b1;
            default:     ;  // NOPs; memory stores are handled in the dmem block
          endcase
          if (flag_upd_s) begin
            zero_r  <= alu_zero_s;
            sign_r  <= alu_sign_s;
            carry_r <= alu_carry_s;
            ovf_r   <= alu_ovf_s;
          end
        end
        ST_DELAY: begin
          if (dly_cnt_r == DLY_LAST) begin
            dly_cnt_r <= 8'd0;
            state_r   <= ST_NEXT;
          end else begin
            dly_cnt_r <= dly_cnt_r + 8'd1;
          end
        end
        ST_NEXT: begin
          pc_r       <= jmp_flag_r ? imm_s : pc_r + 16'd1;
          jmp_flag_r <= 1'b0;
          state_r    <= ST_HALTCHK;
        end
        ST_HALTCHK: state_r <= stop_r ? ST_HALTCHK : ST_FETCH;
        default:    state_r <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mini_risc_core.sv
module tb_mini_risc_core;

  logic        clk = 1'b0;
  logic        sys_rst = 1'b0;
  logic [15:0] din = 16'd0;
  logic [15:0] dout;
  logic [15:0] dout_mul;

  always #5 clk = ~clk;

  mini_risc_core dut (
    .clk(clk), .sys_rst(sys_rst), .din(din), .dout(dout)
  );

  mini_risc_core #(.ROM_VARIANT(1)) dut_mul (
    .clk(clk), .sys_rst(sys_rst), .din(din), .dout(dout_mul)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- ISA-level reference model ----------------
  typedef struct {
    int op; int rd; int rs1; int im; int rs2; int imm;
  } instr_t;

  function automatic instr_t prog_at(input int pc);
    case (pc)
      0: return '{1, 0, 0, 1, 0, 5};   // MOV R0,#5
      1: return '{1, 1, 0, 1, 0, 6};   // MOV R1,#6
      2: return '{1, 2, 0, 1, 0, 0};   // MOV R2,#0
      3: return '{1, 3, 0, 0, 1, 0};   // MOV R3,R1
      4: return '{2, 2, 2, 0, 0, 0};   // ADD R2,R2,R0
      5: return '{3, 3, 3, 1, 0, 1};   // SUB R3,R3,#1
      6: return '{22, 0, 0, 1, 0, 4};  // JNOZERO 4
      7: return '{1, 4, 0, 0, 2, 0};   // MOV R4,R2
      default: return '{25, 0, 0, 1, 0, 0};
    endcase
  endfunction

  int m_gpr [32];
  int m_sgpr, m_zero, m_sign, m_carry, m_ovf;
  int m_pc, m_pc_next, m_stop, m_halt_n, m_add_cnt;
  int n_edge = 0;
  int dut_add_cnt = 0;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_gpr[i] = 0;
    m_sgpr = 0; m_zero = 0; m_sign = 0; m_carry = 0; m_ovf = 0;
    m_pc = 0; m_pc_next = 0; m_stop = 0; m_halt_n = 0; m_add_cnt = 0;
  endtask

  function automatic int to_signed16(input int v);
    return (v >= 32768) ? v - 65536 : v;
  endfunction

  task automatic model_step();
    instr_t ins;
    int a, b, r, sr;
    ins = prog_at(m_pc);
    a = m_gpr[ins.rs1];
    b = (ins.im != 0) ? ins.imm : m_gpr[ins.rs2];
    m_pc_next = (m_pc + 1) % 65536;
    if (m_pc == 4) m_add_cnt++;
    case (ins.op)
      1: m_gpr[ins.rd] = b;
      2, 3: begin
        if (ins.op == 2) begin
          r = a + b;
          m_carry = (r > 65535) ? 1 : 0;
          sr = to_signed16(a) + to_signed16(b);
        end else begin
          r = a - b;
          m_carry = (a < b) ? 1 : 0;
          sr = to_signed16(a) - to_signed16(b);
        end
        m_ovf = (sr > 32767 || sr < -32768) ? 1 : 0;
        r = r & 32'h0000FFFF;
        m_gpr[ins.rd] = r;
        m_zero = (r == 0) ? 1 : 0;
        m_sign = (r >= 32768) ? 1 : 0;
      end
      22: if (m_zero == 0) m_pc_next = ins.imm;
      25: begin m_stop = 1; m_halt_n = n_edge; end
      default: ;
    endcase
  endtask

  function automatic int phase_state(input int ph);
    if (ph == 0) return 1;
    if (ph == 1) return 2;
    if (ph <= 6) return 3;
    if (ph == 7) return 4;
    return 5;
  endfunction

  // Count clock edges since the last reset release.
  always @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) n_edge <= 0;
    else          n_edge <= n_edge + 1;
  end

  // Per-cycle compare of the DUT against the model.
  int ph, exp_state;
  always @(negedge clk) begin
    if (!sys_rst) begin
      model_reset();
      dut_add_cnt = 0;
      exp_state = 0;
    end else begin
      exp_state = 0;
      if (n_edge > 0) begin
        ph = (n_edge - 1) % 9;
        if (m_stop == 0 || n_edge <= m_halt_n + 6) begin
          if (ph == 2 && m_stop == 0) model_step();
          if (ph == 8) m_pc = m_pc_next;
        end
        exp_state = (m_stop != 0 && n_edge >= m_halt_n + 6) ? 5 : phase_state(ph);
      end
      if (int'(dut.state_r) == 2 && int'(dut.pc_r) == 4) dut_add_cnt++;
    end
    chk("state", int'(dut.state_r), exp_state);
    chk("pc", int'(dut.pc_r), m_pc);
    for (int i = 0; i < 32; i++) chk($sformatf("gpr%0d", i), int'(dut.gpr_r[i]), m_gpr[i]);
    chk("sgpr", int'(dut.sgpr_r), m_sgpr);
    chk("zero", int'(dut.zero_r), m_zero);
    chk("sign", int'(dut.sign_r), m_sign);
    chk("carry", int'(dut.carry_r), m_carry);
    chk("ovf", int'(dut.ovf_r), m_ovf);
    chk("stop", int'(dut.stop_r), m_stop);
    chk("dout", int'(dout), 0);
  end

  // Random external data every cycle; the program never samples it.
  initial begin
    forever begin
      @(posedge clk);
      #1 din = 16'($urandom);
    end
  end

  task automatic run_to_halt();
    int cyc;
    int done;
    cyc = 0;
    done = 0;
    while (done == 0 && cyc < 500) begin
      @(posedge clk);
      #1;
      cyc++;
      if (dut.stop_r == 1'b1 && int'(dut.state_r) == 5) done = 1;
    end
    chk("halt_reached", done, 1);
  endtask

  task automatic final_values(input string tag);
    chk({tag, "_gpr0"}, int'(dut.gpr_r[0]), 5);
    chk({tag, "_gpr1"}, int'(dut.gpr_r[1]), 6);
    chk({tag, "_gpr2"}, int'(dut.gpr_r[2]), 30);
    chk({tag, "_gpr3"}, int'(dut.gpr_r[3]), 0);
    chk({tag, "_gpr4"}, int'(dut.gpr_r[4]), 30);
    chk({tag, "_zero"}, int'(dut.zero_r), 1);
    chk({tag, "_add_count"}, dut_add_cnt, 6);
    chk({tag, "_model_gpr2"}, m_gpr[2], 30);
    chk({tag, "_model_add_count"}, m_add_cnt, 6);
  endtask

  initial begin
    int c;
    int exp_r5;
    sys_rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("reset_state", int'(dut.state_r), 0);
    chk("reset_dout", int'(dout), 0);
    sys_rst = 1'b1;

    // First edge after release: FETCH with PC 0.
    @(posedge clk);
    #1;
    chk("first_fetch_state", int'(dut.state_r), 1);
    chk("first_fetch_pc", int'(dut.pc_r), 0);
    chk("first_fetch_dout", int'(dout), 0);

    run_to_halt();
    final_values("run1");

    // Parked in HALTCHK, PC one past the HALT.
    repeat (20) @(posedge clk);
    #1;
    chk("hold_state", int'(dut.state_r), 5);
    chk("hold_pc", int'(dut.pc_r), 9);
    chk("hold_gpr2", int'(dut.gpr_r[2]), 30);

`ifdef MINIRISC_MUL_EN
    exp_r5 = 30;
`else
    exp_r5 = 0;
`endif
    chk("mul_stop", int'(dut_mul.stop_r), 1);
    chk("mul_gpr5", int'(dut_mul.gpr_r[5]), exp_r5);
    chk("mul_sgpr", int'(dut_mul.sgpr_r), 0);

    // Reset at random points inside a DELAY window, then rerun.
    for (int k = 0; k < 3; k++) begin
      sys_rst = 1'b0;
      repeat (2) @(posedge clk);
      #1 sys_rst = 1'b1;
      c = 9 * int'($urandom_range(0, 15)) + 3 + int'($urandom_range(0, 4));
      repeat (c) @(posedge clk);
      #1;
      chk("pre_reset_in_delay", int'(dut.state_r), 3);
      sys_rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("midreset_state", int'(dut.state_r), 0);
      chk("midreset_pc", int'(dut.pc_r), 0);
      chk("midreset_gpr2", int'(dut.gpr_r[2]), 0);
      sys_rst = 1'b1;
      run_to_halt();
      final_values($sformatf("rerun%0d", k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
